// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter encoding,
// the BTB line layout and the saturating counter update.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t STRONG_NT = 2'b00;
    localparam ctr_t WEAK_NT   = 2'b01;
    localparam ctr_t WEAK_T    = 2'b10;
    localparam ctr_t STRONG_T  = 2'b11;

    // Line geometry for the default configuration (32-bit PC, 16 lines).
    localparam int BTB_WIDTH = 32;
    localparam int BTB_TAG_W = 26;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_WIDTH-1:0] target;
        ctr_t                 ctr;
    } btb_line_t;

    // Move the counter one step toward the observed outcome, holding at the ends.
    function automatic ctr_t sat_update(ctr_t c, logic taken);
        ctr_t r;
        r = c;
        if (taken) begin
            if (c != STRONG_T) r = c + 2'd1;
        end else begin
            if (c != STRONG_NT) r = c - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped line storage: one asynchronous read port, one synchronous
// write port. A read of the index being written returns the old contents.
module btb_array #(
    parameter int ENTRIES = 16,
    parameter int LINE_W = 8,
    parameter logic [LINE_W-1:0] RST_LINE = '0,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [LINE_W-1:0] rd_line,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [LINE_W-1:0] wr_line
);

    logic [LINE_W-1:0] mem [ENTRIES];

    // Asynchronous read, no bypass from the write port.
    always_comb begin
        rd_line = mem[rd_idx];
    end

    // Reset clears every line; otherwise a single-line write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) mem[i] <= RST_LINE;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_line;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit counters, looked up
// in Fetch, trained from Execute, with mispredict detection and statistics.
// The external PC mux must give MispredictE/PCRedirectE priority over
// PredTakenF/PCPredictF.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ENTRIES = 16,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  PCF,
    output logic              PredTakenF,
    output logic [WIDTH-1:0]  PCPredictF,
    input  logic              BranchE,
    input  logic              JumpE,
    input  logic              TakenE,
    input  logic [WIDTH-1:0]  PCE,
    input  logic [WIDTH-1:0]  PCTargetE,
    input  logic              PredTakenE,
    input  logic [WIDTH-1:0]  PredTargetE,
    output logic              MispredictE,
    output logic [WIDTH-1:0]  PCRedirectE,
    output logic [STAT_W-1:0] BranchCount,
    output logic [STAT_W-1:0] MispredictCount
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = WIDTH - 2 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] target;
        ctr_t             ctr;
    } line_t;

    localparam int LINE_W = $bits(line_t);
    localparam line_t RST_LINE = '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    logic [IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    line_t            line_f, line_e, line_wr;
    logic             hit_f, hit_e, act, resolving, wr_en;

    assign idx_f = PCF[IDX_W+1:2];
    assign tag_f = PCF[WIDTH-1:IDX_W+2];
    assign idx_e = PCE[IDX_W+1:2];
    assign tag_e = PCE[WIDTH-1:IDX_W+2];

    assign act       = JumpE | TakenE;
    assign resolving = BranchE | JumpE;

    // Storage is replicated so Fetch and Execute each get a private read
    // port; both copies receive identical writes and so always agree.
    btb_array #(.ENTRIES(ENTRIES), .LINE_W(LINE_W), .RST_LINE(RST_LINE)) u_btb_fetch (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (idx_f),
        .rd_line (line_f),
        .wr_en   (wr_en),
        .wr_idx  (idx_e),
        .wr_line (line_wr)
    );

    btb_array #(.ENTRIES(ENTRIES), .LINE_W(LINE_W), .RST_LINE(RST_LINE)) u_btb_exec (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (idx_e),
        .rd_line (line_e),
        .wr_en   (wr_en),
        .wr_idx  (idx_e),
        .wr_line (line_wr)
    );

    // Fetch lookup: predict taken only on a hit with a taken-leaning counter.
    always_comb begin
        hit_f      = line_f.valid && (line_f.tag == tag_f);
        PredTakenF = hit_f && line_f.ctr[1];
        PCPredictF = PredTakenF ? line_f.target : (PCF + PC_STEP);
    end

    // Execute resolve: direction or target disagreement forces a redirect.
    always_comb begin
        MispredictE = 1'b0;
        PCRedirectE = '0;
        if (resolving) begin
            MispredictE = (PredTakenE != act) ||
                          (act && PredTakenE && (PredTargetE != PCTargetE));
            PCRedirectE = act ? PCTargetE : (PCE + PC_STEP);
        end
    end

    // Training: update a hit line, allocate on a taken miss, skip a not-taken miss.
    always_comb begin
        hit_e   = line_e.valid && (line_e.tag == tag_e);
        wr_en   = 1'b0;
        line_wr = line_e;
        if (resolving) begin
            if (hit_e) begin
                wr_en = 1'b1;
                if (JumpE) begin
                    line_wr.ctr    = STRONG_T;
                    line_wr.target = PCTargetE;
                end else begin
                    line_wr.ctr = sat_update(line_e.ctr, act);
                    if (act) line_wr.target = PCTargetE;
                end
            end else if (act) begin
                wr_en          = 1'b1;
                line_wr.valid  = 1'b1;
                line_wr.tag    = tag_e;
                line_wr.target = PCTargetE;
                line_wr.ctr    = JumpE ? STRONG_T : WEAK_T;
            end
        end
    end

    // Performance counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            BranchCount     <= '0;
            MispredictCount <= '0;
        end else begin
            if (resolving && (BranchCount != '1))
                BranchCount <= BranchCount + STAT_W'(1);
            if (MispredictE && (MispredictCount != '1))
                MispredictCount <= MispredictCount + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (WIDTH=32, ENTRIES=16, STAT_W=32).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PCPredictF;
    logic        BranchE, JumpE, TakenE;
    logic [31:0] PCE, PCTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredictE;
    logic [31:0] PCRedirectE;
    logic [31:0] BranchCount, MispredictCount;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.WIDTH(32), .ENTRIES(16), .STAT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .PCF             (PCF),
        .PredTakenF      (PredTakenF),
        .PCPredictF      (PCPredictF),
        .BranchE         (BranchE),
        .JumpE           (JumpE),
        .TakenE          (TakenE),
        .PCE             (PCE),
        .PCTargetE       (PCTargetE),
        .PredTakenE      (PredTakenE),
        .PredTargetE     (PredTargetE),
        .MispredictE     (MispredictE),
        .PCRedirectE     (PCRedirectE),
        .BranchCount     (BranchCount),
        .MispredictCount (MispredictCount)
    );

    // Clock and global timeout.
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        BranchE = 0; JumpE = 0; TakenE = 0; PCE = 0;
        PCTargetE = 0; PredTakenE = 0; PredTargetE = 0;
    endtask

    // Present one Execute instruction away from the clock edge.
    task automatic drive_resolve(input logic br, input logic jmp, input logic tkn,
                                 input logic [31:0] pce, input logic [31:0] tgt,
                                 input logic pte, input logic [31:0] ptgt);
        @(negedge clk);
        BranchE = br; JumpE = jmp; TakenE = tkn; PCE = pce;
        PCTargetE = tgt; PredTakenE = pte; PredTargetE = ptgt;
        #1;
    endtask

    // Let the update edge happen, then return Execute to a bubble.
    task automatic commit();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic look(input logic [31:0] pc);
        PCF = pc;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; idle(); PCF = 32'h40;
        repeat (2) @(posedge clk);
        #1; rst = 0;
        look(32'h40);
        checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b want 0", PredTakenF); end
        checks++; if (PCPredictF !== 32'h44) begin errors++; $display("FAIL reset_target: got %h want 00000044", PCPredictF); end
        checks++; if (BranchCount !== 32'd0) begin errors++; $display("FAIL reset_bcount: got %0d want 0", BranchCount); end
        checks++; if (MispredictCount !== 32'd0) begin errors++; $display("FAIL reset_mcount: got %0d want 0", MispredictCount); end
        checks++; if (MispredictE !== 1'b0 || PCRedirectE !== 32'h0) begin errors++; $display("FAIL idle_resolve: got %b/%h want 0/00000000", MispredictE, PCRedirectE); end
    endtask

    task automatic test_train();
        drive_resolve(1, 0, 1, 32'h40, 32'h20, 0, 32'h0);
        checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL train_mis: got %b want 1", MispredictE); end
        checks++; if (PCRedirectE !== 32'h20) begin errors++; $display("FAIL train_redir: got %h want 00000020", PCRedirectE); end
        commit();
        look(32'h40);
        checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL train_pred: got %b want 1", PredTakenF); end
        checks++; if (PCPredictF !== 32'h20) begin errors++; $display("FAIL train_target: got %h want 00000020", PCPredictF); end
        checks++; if (MispredictCount !== 32'd1) begin errors++; $display("FAIL train_mcount: got %0d want 1", MispredictCount); end
        checks++; if (BranchCount !== 32'd1) begin errors++; $display("FAIL train_bcount: got %0d want 1", BranchCount); end
    endtask

    task automatic test_counter_saturation();
        // ctr 10 -> 01, predicted taken but not taken
        drive_resolve(1, 0, 0, 32'h40, 32'h20, 1, 32'h20);
        checks++; if (MispredictE !== 1'b1 || PCRedirectE !== 32'h44) begin errors++; $display("FAIL nt1_resolve: got %b/%h want 1/00000044", MispredictE, PCRedirectE); end
        commit();
        look(32'h40);
        checks++; if (PredTakenF !== 1'b0 || PCPredictF !== 32'h44) begin errors++; $display("FAIL nt1_pred: got %b/%h want 0/00000044", PredTakenF, PCPredictF); end
        // ctr 01 -> 00, then held at 00
        drive_resolve(1, 0, 0, 32'h40, 32'h20, 0, 32'h0);
        checks++; if (MispredictE !== 1'b0 || PCRedirectE !== 32'h44) begin errors++; $display("FAIL nt2_resolve: got %b/%h want 0/00000044", MispredictE, PCRedirectE); end
        commit();
        drive_resolve(1, 0, 0, 32'h40, 32'h20, 0, 32'h0);
        commit();
        // one taken from 00 gives 01 (still not taken); a wrapped counter would predict taken
        drive_resolve(1, 0, 1, 32'h40, 32'h20, 0, 32'h0);
        commit();
        look(32'h40);
        checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL sat_low_pred: got %b want 0", PredTakenF); end
        drive_resolve(1, 0, 1, 32'h40, 32'h20, 0, 32'h0);
        commit();
        look(32'h40);
        checks++; if (PredTakenF !== 1'b1 || PCPredictF !== 32'h20) begin errors++; $display("FAIL retrain_pred: got %b/%h want 1/00000020", PredTakenF, PCPredictF); end
        checks++; if (BranchCount !== 32'd6 || MispredictCount !== 32'd4) begin errors++; $display("FAIL sat_counts: got %0d/%0d want 6/4", BranchCount, MispredictCount); end
    endtask

    task automatic test_jump_alias();
        // jal at 0x80 shares index 0 with 0x40: allocation evicts it
        drive_resolve(0, 1, 0, 32'h80, 32'h100, 1, 32'h0FC);
        checks++; if (MispredictE !== 1'b1 || PCRedirectE !== 32'h100) begin errors++; $display("FAIL jal_resolve: got %b/%h want 1/00000100", MispredictE, PCRedirectE); end
        commit();
        look(32'h80);
        checks++; if (PredTakenF !== 1'b1 || PCPredictF !== 32'h100) begin errors++; $display("FAIL jal_pred: got %b/%h want 1/00000100", PredTakenF, PCPredictF); end
        look(32'h40);
        checks++; if (PredTakenF !== 1'b0 || PCPredictF !== 32'h44) begin errors++; $display("FAIL alias_evict: got %b/%h want 0/00000044", PredTakenF, PCPredictF); end
        // jump hit with a new target
        drive_resolve(0, 1, 0, 32'h80, 32'h200, 1, 32'h100);
        checks++; if (MispredictE !== 1'b1 || PCRedirectE !== 32'h200) begin errors++; $display("FAIL jal_retarget: got %b/%h want 1/00000200", MispredictE, PCRedirectE); end
        commit();
        look(32'h80);
        checks++; if (PCPredictF !== 32'h200) begin errors++; $display("FAIL jal_newtarget: got %h want 00000200", PCPredictF); end
        drive_resolve(0, 1, 0, 32'h80, 32'h200, 1, 32'h200);
        checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL jal_correct: got %b want 0", MispredictE); end
        commit();
        // not-taken miss must not allocate
        drive_resolve(1, 0, 0, 32'h10, 32'h300, 0, 32'h0);
        checks++; if (MispredictE !== 1'b0 || PCRedirectE !== 32'h14) begin errors++; $display("FAIL ntmiss_resolve: got %b/%h want 0/00000014", MispredictE, PCRedirectE); end
        commit();
        look(32'h10);
        checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL ntmiss_noalloc: got %b want 0", PredTakenF); end
    endtask

    task automatic test_collision();
        PCF = 32'h10;
        drive_resolve(1, 0, 1, 32'h10, 32'h300, 0, 32'h0);
        checks++; if (PredTakenF !== 1'b0 || PCPredictF !== 32'h14) begin errors++; $display("FAIL coll_alloc_old: got %b/%h want 0/00000014", PredTakenF, PCPredictF); end
        commit();
        look(32'h10);
        checks++; if (PredTakenF !== 1'b1 || PCPredictF !== 32'h300) begin errors++; $display("FAIL coll_alloc_new: got %b/%h want 1/00000300", PredTakenF, PCPredictF); end
        drive_resolve(1, 0, 1, 32'h10, 32'h340, 1, 32'h300);
        checks++; if (PCPredictF !== 32'h300) begin errors++; $display("FAIL coll_same_cycle: got %h want 00000300", PCPredictF); end
        checks++; if (MispredictE !== 1'b1 || PCRedirectE !== 32'h340) begin errors++; $display("FAIL coll_target_mis: got %b/%h want 1/00000340", MispredictE, PCRedirectE); end
        commit();
        look(32'h10);
        checks++; if (PCPredictF !== 32'h340) begin errors++; $display("FAIL coll_after: got %h want 00000340", PCPredictF); end
        checks++; if (BranchCount !== 32'd12 || MispredictCount !== 32'd8) begin errors++; $display("FAIL coll_counts: got %0d/%0d want 12/8", BranchCount, MispredictCount); end
    endtask

    task automatic test_reset_mid();
        drive_resolve(1, 0, 1, 32'h60, 32'h400, 0, 32'h0);
        rst = 1; #1;
        checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL rst_comb_mis: got %b want 1", MispredictE); end
        commit();
        rst = 0;
        look(32'h60);
        checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL rst_mid_noalloc: got %b want 0", PredTakenF); end
        look(32'h10);
        checks++; if (PredTakenF !== 1'b0 || PCPredictF !== 32'h14) begin errors++; $display("FAIL rst_mid_clear: got %b/%h want 0/00000014", PredTakenF, PCPredictF); end
        checks++; if (BranchCount !== 32'd0 || MispredictCount !== 32'd0) begin errors++; $display("FAIL rst_mid_counts: got %0d/%0d want 0/0", BranchCount, MispredictCount); end
    endtask

    task automatic test_back_to_back();
        drive_resolve(1, 0, 1, 32'h24, 32'h8, 0, 32'h0);
        @(posedge clk);
        drive_resolve(1, 0, 1, 32'h24, 32'h8, 1, 32'h8);
        checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL b2b_second: got %b want 0", MispredictE); end
        @(posedge clk);
        drive_resolve(1, 0, 0, 32'h24, 32'h8, 1, 32'h8);
        checks++; if (MispredictE !== 1'b1 || PCRedirectE !== 32'h28) begin errors++; $display("FAIL b2b_third: got %b/%h want 1/00000028", MispredictE, PCRedirectE); end
        commit();
        look(32'h24);
        checks++; if (PredTakenF !== 1'b1 || PCPredictF !== 32'h8) begin errors++; $display("FAIL b2b_pred: got %b/%h want 1/00000008", PredTakenF, PCPredictF); end
        checks++; if (BranchCount !== 32'd3 || MispredictCount !== 32'd2) begin errors++; $display("FAIL b2b_counts: got %0d/%0d want 3/2", BranchCount, MispredictCount); end
    endtask

    initial begin
        test_reset();
        test_train();
        test_counter_saturation();
        test_jump_alias();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
